// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch and memory-stage requesters share one
// request/ack memory device, with a fairness cap and an access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 16,
  parameter int FAIR_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_error,
  output logic              stall
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int FW = (FAIR_MAX > 0) ? $clog2(FAIR_MAX + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FAIR_TOP = FW'(FAIR_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS_I = 2'd1,
    ACCESS_D = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [TW-1:0]     tmo_reg, tmo_next;
  logic [FW-1:0]     fair_reg, fair_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
  logic              if_ready_reg, if_ready_next;
  logic              dm_ready_reg, dm_ready_next;
  logic              bus_error_reg, bus_error_next;

  logic dm_any;
  logic fetch_wins;
  logic tmo_expired;

  assign dm_any      = dm_read | dm_write;
  // Data normally wins; fetch takes over once data has used up its fairness budget.
  assign fetch_wins  = if_req & (~dm_any | (fair_reg == FAIR_TOP));
  assign tmo_expired = (tmo_reg == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      tmo_reg       <= '0;
      fair_reg      <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_ready_reg  <= 1'b0;
      dm_ready_reg  <= 1'b0;
      bus_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tmo_reg       <= tmo_next;
      fair_reg      <= fair_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      if_ready_reg  <= if_ready_next;
      dm_ready_reg  <= dm_ready_next;
      bus_error_reg <= bus_error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (fetch_wins) state_next = ACCESS_I;
        else if (dm_any) state_next = ACCESS_D;
      end
      ACCESS_I, ACCESS_D: begin
        if (mem_ack || tmo_expired) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tmo_next       = tmo_reg;
    fair_next      = fair_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    if_ready_next  = 1'b0;
    dm_ready_next  = 1'b0;
    bus_error_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (fetch_wins) begin
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = if_addr;
          tmo_next      = '0;
          fair_next     = '0;
        end else if (dm_any) begin
          mem_req_next   = 1'b1;
          mem_we_next    = dm_write;
          mem_addr_next  = dm_addr;
          mem_wdata_next = dm_wdata;
          tmo_next       = '0;
          if (if_req && (fair_reg != FAIR_TOP)) fair_next = fair_reg + 1'b1;
        end
      end
      ACCESS_I, ACCESS_D: begin
        // An ack in the final allowed cycle still counts as a normal completion.
        if (mem_ack) begin
          mem_req_next = 1'b0;
          if (state_reg == ACCESS_I) begin
            if_ready_next = 1'b1;
            if_rdata_next = mem_rdata;
          end else begin
            dm_ready_next = 1'b1;
            if (!mem_we_reg) dm_rdata_next = mem_rdata;
          end
        end else if (tmo_expired) begin
          mem_req_next   = 1'b0;
          bus_error_next = 1'b1;
          if (state_reg == ACCESS_I) begin
            if_ready_next = 1'b1;
            if_rdata_next = '0;
          end else begin
            dm_ready_next = 1'b1;
            dm_rdata_next = '0;
          end
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign stall     = (if_req | dm_any) & (state_reg != DONE);
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign if_ready  = if_ready_reg;
  assign dm_ready  = dm_ready_reg;
  assign bus_error = bus_error_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, fairness and reset
// sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT  = 16;
  localparam int FAIR_MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_read, dm_write, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we, bus_error, stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .FAIR_MAX(FAIR_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_error(bus_error), .stall(stall)
  );

  typedef struct {
    logic        fi;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;      // access cycle carrying the ack, 0 = never
    logic        exp_we;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;  // cycles with mem_req high
  } vec_t;

  vec_t vecs[8];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          n_req;
    bit          got;
    logic [31:0] act_rd;
    if_req = v.fi; if_addr = v.addr;
    dm_read = v.rd; dm_write = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
    mem_ack = 1'b0;
    n_req = 0; got = 0;
    for (int c = 0; c < TIMEOUT + 8 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 0) chk1("grant_latency", mem_req, 1'b1);
      if (if_ready || dm_ready) begin
        got = 1; mem_ack = 1'b0;
        act_rd = v.fi ? if_rdata : dm_rdata;
        chk1("ready_if", if_ready, v.fi);
        chk1("ready_dm", dm_ready, !v.fi);
        chk32("rdata", act_rd, v.exp_rd);
        chk1("bus_error", bus_error, v.exp_err);
        chk32("access_cycles", 32'(n_req), 32'(v.exp_cyc));
        chk1("req_dropped", mem_req, 1'b0);
      end else if (mem_req) begin
        n_req++;
        chk32("mem_addr_stable", mem_addr, v.addr);
        chk1("mem_we", mem_we, v.exp_we);
        if (v.exp_we) chk32("mem_wdata_stable", mem_wdata, v.wdata);
        mem_ack   = (n_req == v.dly);
        mem_rdata = mem_ack ? v.rdata : 32'h5555_AAAA;
      end
    end
    if (!got) chk1("ready_seen", 1'b0, 1'b1);
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
    @(posedge clk); #1;
    chk1("ready_one_cycle", if_ready | dm_ready, 1'b0);
    chk1("bus_error_one_cycle", bus_error, 1'b0);
    $display("vec %0d: %s addr=%08h cycles=%0d rdata=%08h err=%0d",
             idx, v.fi ? "fetch" : (v.wr ? "write" : "read"), v.addr, n_req, act_rd, bus_error);
  endtask

  task automatic reset_mid_access();
    dm_read = 1'b1; dm_write = 1'b0; dm_addr = 32'h500; mem_ack = 1'b0;
    @(posedge clk); #1; chk1("rst_access_started", mem_req, 1'b1);
    @(posedge clk); #1; chk1("rst_access_held", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("rst_async_mem_req", mem_req, 1'b0);
    chk1("rst_async_dm_ready", dm_ready, 1'b0);
    chk1("rst_async_bus_error", bus_error, 1'b0);
    chk32("rst_async_mem_addr", mem_addr, 32'h0);
    dm_read = 1'b0;
    @(posedge clk); #1;
    chk1("rst_held_dm_ready", dm_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("rst_after_mem_req", mem_req, 1'b0);
    chk1("rst_after_dm_ready", dm_ready, 1'b0);
    $display("reset mid-access: access abandoned");
    run_vec(vecs[7], 7);
  endtask

  // Both requesters held, ack in the first access cycle: each grant takes
  // three cycles (access, done, idle) and fetch gets every third slot.
  task automatic fairness_seq();
    bit exp_acc, exp_rdy, exp_i;
    do_reset();
    if_req = 1'b1; dm_read = 1'b1; dm_write = 1'b0;
    if_addr = 32'h300; dm_addr = 32'h400; mem_ack = 1'b0;
    #1 chk1("fair_stall_c0", stall, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      exp_acc = (c % 3 == 1);
      exp_rdy = (c % 3 == 2);
      exp_i   = exp_rdy && (((c - 2) / 3) % 3 == 2);
      chk1("fair_mem_req", mem_req, exp_acc);
      chk1("fair_if_ready", if_ready, exp_i);
      chk1("fair_dm_ready", dm_ready, exp_rdy && !exp_i);
      chk1("fair_stall", stall, !exp_rdy);
      if (exp_rdy) begin
        chk32("fair_rdata", exp_i ? if_rdata : dm_rdata, 32'(c - 1));
        $display("fair grant %0d: %s", (c - 2) / 3, exp_i ? "I" : "D");
      end
      mem_ack   = exp_acc;
      mem_rdata = 32'(c);
      if (c == 17) begin if_req = 1'b0; dm_read = 1'b0; end
    end
    mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  // Transaction-level reference: who wins, when it finishes (grant + ack
  // cycle or grant + TIMEOUT), and what read data each side should hold.
  task automatic run_random(input int n_txn);
    int          cyc, g, e, free_edge, fair, d, win, fin, ntx, r;
    bit          tmo, we, in_done, dsel, acc;
    logic [31:0] addr, v, exp_ird, exp_drd;
    cyc = 0; g = 0; e = 0; free_edge = 1; fair = 0; d = 0; win = 0; ntx = 0;
    tmo = 0; we = 0; addr = 0; v = 0; exp_ird = 0; exp_drd = 0;
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
    while (ntx < n_txn && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (win == 0 && cyc >= free_edge && (if_req || dm_read || dm_write)) begin
        dsel = (dm_read || dm_write) && !(if_req && fair == FAIR_MAX);
        if (dsel) begin
          win = 2; addr = dm_addr; we = dm_write;
          if (if_req && fair < FAIR_MAX) fair++;
        end else begin
          win = 1; addr = if_addr; we = 1'b0; fair = 0;
        end
        d = int'($urandom_range(0, 7));
        if (d == 7) d = TIMEOUT;
        tmo = (d == 0);
        g = cyc;
        e = cyc + (tmo ? TIMEOUT : d);
      end
      acc     = (win != 0 && cyc < e);
      in_done = (win != 0 && cyc == e);
      if (in_done) begin
        if (win == 1) exp_ird = tmo ? 32'h0 : v;
        else if (tmo) exp_drd = 32'h0;
        else if (!we) exp_drd = v;
      end
      chk1("rnd_mem_req", mem_req, acc);
      if (acc) begin
        chk32("rnd_mem_addr", mem_addr, addr);
        chk1("rnd_mem_we", mem_we, we);
        if (we) chk32("rnd_mem_wdata", mem_wdata, dm_wdata);
      end
      chk1("rnd_if_ready", if_ready, in_done && win == 1);
      chk1("rnd_dm_ready", dm_ready, in_done && win == 2);
      chk1("rnd_bus_error", bus_error, in_done && tmo);
      chk32("rnd_if_rdata", if_rdata, exp_ird);
      chk32("rnd_dm_rdata", dm_rdata, exp_drd);
      fin = 0;
      if (in_done) begin
        $display("rnd %0d: %s addr=%08h we=%0d lat=%0d%s", ntx, win == 1 ? "I" : "D",
                 addr, we, e - g, tmo ? " timeout" : "");
        ntx++;
        free_edge = e + 2;
        fin = win;
        win = 0;
      end
      if (fin == 1 || !if_req) begin
        if_req  = ($urandom_range(0, 1) == 1);
        if_addr = $urandom;
      end
      if (fin == 2 || !(dm_read || dm_write)) begin
        r = int'($urandom_range(0, 5));
        dm_read  = (r == 1 || r == 2 || r == 5);
        dm_write = (r == 3 || r == 4 || r == 5);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
      mem_rdata = $urandom;
      if (acc) mem_ack = (d != 0 && cyc == e - 1);
      else     mem_ack = ($urandom_range(0, 1) == 1);
      if (acc && mem_ack) v = mem_rdata;
      #1 chk1("rnd_stall", stall, (if_req || dm_read || dm_write) && !in_done);
    end
    if (ntx < n_txn) chk1("rnd_cycle_budget", 1'b0, 1'b1);
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    // fi rd wr addr wdata rdata dly exp_we exp_rd exp_err exp_cyc
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,        32'h00A00093, 1,       1'b0, 32'h00A00093, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 32'h0,        3,       1'b1, 32'h0,        1'b0, 3};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h40,   32'h0,        32'hCAFEF00D, 2,       1'b0, 32'hCAFEF00D, 1'b0, 2};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h48,   32'h12345678, 32'hFFFF0000, 1,       1'b1, 32'hCAFEF00D, 1'b0, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h44,   32'h0,        32'h0,        0,       1'b0, 32'h0,        1'b1, TIMEOUT};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h104,  32'h0,        32'h13579BDF, TIMEOUT, 1'b0, 32'h13579BDF, 1'b0, TIMEOUT};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h108,  32'h0,        32'h0,        0,       1'b0, 32'h0,        1'b1, TIMEOUT};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h200,  32'h0,        32'h0BADF00D, 2,       1'b0, 32'h0BADF00D, 1'b0, 2};

    rst = 1'b0;
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    @(posedge clk); #1;
    chk1("reset_mem_req", mem_req, 1'b0);
    rst = 1'b1;
    #1;
    chk1("reset_if_ready", if_ready, 1'b0);
    chk1("reset_dm_ready", dm_ready, 1'b0);
    chk1("reset_bus_error", bus_error, 1'b0);
    chk1("reset_mem_we", mem_we, 1'b0);
    chk1("reset_stall", stall, 1'b0);
    chk32("reset_if_rdata", if_rdata, 32'h0);
    chk32("reset_dm_rdata", dm_rdata, 32'h0);
    chk32("reset_mem_addr", mem_addr, 32'h0);
    chk32("reset_mem_wdata", mem_wdata, 32'h0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    reset_mid_access();
    fairness_seq();
    do_reset();
    run_random(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
